// File: rtl/of_drain_unit.sv
// Output-feature drain engine: snapshots the PE partial-sum array, then streams
// one requantised row per beat (ReLU, rounding shift, signed saturation).
module of_drain_unit #(
  parameter int X_DIM     = 16,
  parameter int Y_DIM     = 16,
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter int SH_W      = $clog2(ACC_WIDTH)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [X_DIM-1:0][Y_DIM-1:0][ACC_WIDTH-1:0]   pe_of_in,
  input  logic                                         capture_req,
  input  logic                                         relu_en,
  input  logic [SH_W-1:0]                              shift_amt,
  output logic                                         busy,
  output logic                                         capture_err,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [Y_DIM-1:0][OUT_WIDTH-1:0]              out_data,
  output logic [$clog2(X_DIM)-1:0]                     out_row,
  output logic                                         out_last,
  output logic                                         sat_flag,
  output logic                                         done
);

  localparam int ROW_W = $clog2(X_DIM);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(X_DIM - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, DRAIN} state_t;

  state_t state;
  state_t state_next;

  logic [X_DIM-1:0][Y_DIM-1:0][ACC_WIDTH-1:0] shadow;
  logic                                       relu_lat;
  logic [SH_W-1:0]                            shift_lat;

  logic                                       capture_ok;
  logic                                       beat_taken;
  logic [ROW_W-1:0]                           sel_row;
  logic [Y_DIM-1:0][OUT_WIDTH-1:0]            row_q;
  logic [Y_DIM-1:0]                           lane_sat;

  // Returns {saturated, value}. The extra headroom bit keeps v + 2^(s-1) from wrapping.
  function automatic logic [OUT_WIDTH:0] requant(
    input logic [ACC_WIDTH-1:0] v,
    input logic                 relu,
    input logic [SH_W-1:0]      s
  );
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] rnd;
    logic signed [ACC_WIDTH:0] res;
    logic [OUT_WIDTH-1:0]      q;
    logic                      sat;
    ext = {v[ACC_WIDTH-1], v};
    if (relu && v[ACC_WIDTH-1]) begin
      ext = '0;
    end
    if (s != '0) begin
      rnd = (ACC_WIDTH + 1)'(1) << (s - 1'b1);
      res = (ext + rnd) >>> s;
    end else begin
      rnd = '0;
      res = ext;
    end
    if (res > SAT_MAX) begin
      q   = SAT_MAX[OUT_WIDTH-1:0];
      sat = 1'b1;
    end else if (res < SAT_MIN) begin
      q   = SAT_MIN[OUT_WIDTH-1:0];
      sat = 1'b1;
    end else begin
      q   = res[OUT_WIDTH-1:0];
      sat = 1'b0;
    end
    return {sat, q};
  endfunction

  assign capture_ok = (state == IDLE) && capture_req;
  assign beat_taken = (state == DRAIN) && out_valid && out_ready;

  // PREP fetches row 0; in DRAIN the row after the one on the bus is precomputed.
  assign sel_row = ((state == DRAIN) && !out_last) ? out_row + 1'b1 : '0;

  for (genvar gi = 0; gi < Y_DIM; gi++) begin : g_lane
    assign {lane_sat[gi], row_q[gi]} = requant(shadow[sel_row][gi], relu_lat, shift_lat);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture_req) state_next = PREP;
      PREP:    state_next = DRAIN;
      DRAIN:   if (out_valid && out_ready && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow      <= '0;
      relu_lat    <= 1'b0;
      shift_lat   <= '0;
      busy        <= 1'b0;
      capture_err <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_row     <= '0;
      out_last    <= 1'b0;
      sat_flag    <= 1'b0;
      done        <= 1'b0;
    end else begin
      capture_err <= capture_req && (state != IDLE);
      done        <= 1'b0;

      if (capture_ok) begin
        shadow    <= pe_of_in;
        relu_lat  <= relu_en;
        shift_lat <= shift_amt;
        out_row   <= '0;
        busy      <= 1'b1;
      end

      if (state == PREP) begin
        out_valid <= 1'b1;
        out_data  <= row_q;
        sat_flag  <= |lane_sat;
        out_row   <= '0;
        out_last  <= (LAST_ROW == '0);
      end else if (beat_taken) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          sat_flag  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end else begin
          out_row   <= sel_row;
          out_data  <= row_q;
          sat_flag  <= |lane_sat;
          out_last  <= (sel_row == LAST_ROW);
        end
      end
    end
  end

endmodule

// File: tb/tb_of_drain_unit.sv
// Randomised bench for of_drain_unit: a per-element arithmetic model plus
// cycle-level expectations for drain timing, backpressure and capture collisions.
module tb_of_drain_unit;

  localparam int X  = 4;
  localparam int Y  = 4;
  localparam int A  = 16;
  localparam int O  = 8;
  localparam int SW = $clog2(A);
  localparam int OMAX = (1 << (O - 1)) - 1;
  localparam int OMIN = -(1 << (O - 1));

  typedef logic [X-1:0][Y-1:0][A-1:0] mat_t;
  typedef logic [Y-1:0][O-1:0] row_t;
  typedef struct {
    row_t data;
    int   row;
    logic last;
    logic sat;
    int   k;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  mat_t            pe_of_in = '0;
  logic            capture_req = 1'b0;
  logic            relu_en = 1'b0;
  logic [SW-1:0]   shift_amt = '0;
  logic            busy, capture_err, out_valid;
  logic            out_ready = 1'b1;
  row_t            out_data;
  logic [$clog2(X)-1:0] out_row;
  logic            out_last, sat_flag, done;

  int n_cmp = 0;
  int n_bad = 0;
  beat_t shown[$];
  beat_t acc[$];
  int done_k, err_k, err_n;
  logic busy1, valid1, busy_done;

  of_drain_unit #(.X_DIM(X), .Y_DIM(Y), .ACC_WIDTH(A), .OUT_WIDTH(O), .SH_W(SW)) dut (
    .clk(clk), .rst(rst), .pe_of_in(pe_of_in), .capture_req(capture_req),
    .relu_en(relu_en), .shift_amt(shift_amt), .busy(busy), .capture_err(capture_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_last(out_last), .sat_flag(sat_flag), .done(done)
  );

  always #5 clk = ~clk;

  // Unclamped result: ReLU, then round-half-up division by 2^s using floor semantics.
  function automatic int ref_raw(int v, bit relu, int s);
    int d, t;
    if (relu && v < 0) v = 0;
    if (s == 0) return v;
    d = 1 << s;
    t = v + d / 2;
    if (t >= 0) return t / d;
    return -((-t + d - 1) / d);
  endfunction

  task automatic model_row(input mat_t m, input bit relu, input int s, input int r,
                           output row_t d, output logic st);
    int q;
    st = 1'b0;
    d  = '0;
    for (int y = 0; y < Y; y++) begin
      q = ref_raw($signed(m[r][y]), relu, s);
      if (q > OMAX) begin q = OMAX; st = 1'b1; end
      if (q < OMIN) begin q = OMIN; st = 1'b1; end
      d[y] = q[O-1:0];
    end
  endtask

  function automatic mat_t rand_mat();
    mat_t m;
    for (int x = 0; x < X; x++)
      for (int y = 0; y < Y; y++)
        m[x][y] = ($urandom_range(0, 1) == 1) ? A'($urandom) : A'($urandom_range(0, 2047) - 1024);
    return m;
  endfunction

  task automatic start_capture(input mat_t m, input bit relu, input int s);
    pe_of_in    = m;
    relu_en     = relu;
    shift_amt   = SW'(s);
    capture_req = 1'b1;
    @(posedge clk);
    #1;
    capture_req = 1'b0;
  endtask

  // Cycle k=1 is the cycle right after the capture edge; bounded at 60 cycles.
  task automatic collect(input logic [63:0] stall, input int poke, input bit chg_set);
    beat_t b;
    shown.delete();
    acc.delete();
    done_k = -1; err_k = -1; err_n = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      out_ready   = !stall[k];
      capture_req = (k == poke);
      for (int x = 0; x < X; x++)
        for (int y = 0; y < Y; y++)
          pe_of_in[x][y] = A'($urandom);
      if (chg_set) begin
        relu_en   = 1'($urandom);
        shift_amt = SW'($urandom);
      end
      if (k == 1) begin
        busy1  = busy;
        valid1 = out_valid;
      end
      if (out_valid === 1'b1) begin
        b.data = out_data; b.row = int'(out_row); b.last = out_last; b.sat = sat_flag; b.k = k;
        shown.push_back(b);
        if (out_ready) acc.push_back(b);
      end
      if (capture_err === 1'b1) begin
        err_n++;
        if (err_k < 0) err_k = k;
      end
      if (done === 1'b1) begin
        done_k    = k;
        busy_done = busy;
        break;
      end
    end
    capture_req = 1'b0;
    out_ready   = 1'b1;
  endtask

  task automatic test_reset();
    mat_t m;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({busy, capture_err, out_valid, out_data, out_row, out_last, sat_flag, done} !== '0)
      begin n_bad++; $display("FAIL reset_init got=%0h exp=0", {busy, capture_err, out_valid, out_data, out_row, out_last, sat_flag, done}); end
    rst = 1'b1;
    for (int x = 0; x < X; x++)
      for (int y = 0; y < Y; y++)
        m[x][y] = A'(16 * x + y + 1);
    start_capture(m, 1'b0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL reset_pre_valid got=%b exp=1", out_valid); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({busy, capture_err, out_valid, out_data, out_row, out_last, sat_flag, done} !== '0)
      begin n_bad++; $display("FAIL reset_async got=%0h exp=0", {busy, capture_err, out_valid, out_data, out_row, out_last, sat_flag, done}); end
    @(posedge clk); #3 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({out_valid, busy, done} !== 3'b000)
        begin n_bad++; $display("FAIL reset_idle cyc=%0d got=%b exp=000", i, {out_valid, busy, done}); end
    end
  endtask

  task automatic test_basic();
    mat_t m;
    logic [O-1:0] e;
    for (int x = 0; x < X; x++)
      for (int y = 0; y < Y; y++)
        m[x][y] = A'(16 * x + y);
    start_capture(m, 1'b0, 0);
    collect(64'h0, -1, 1'b0);
    n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL basic_busy got=%b exp=1", busy1); end
    n_cmp++; if (valid1 !== 1'b0) begin n_bad++; $display("FAIL basic_valid_k1 got=%b exp=0", valid1); end
    n_cmp++; if (acc.size() !== X) begin n_bad++; $display("FAIL basic_count got=%0d exp=%0d", acc.size(), X); end
    foreach (acc[i]) begin
      n_cmp++; if (acc[i].row !== i) begin n_bad++; $display("FAIL basic_row got=%0d exp=%0d", acc[i].row, i); end
      n_cmp++; if (acc[i].k !== i + 2) begin n_bad++; $display("FAIL basic_cycle row=%0d got=%0d exp=%0d", i, acc[i].k, i + 2); end
      for (int y = 0; y < Y; y++) begin
        e = O'(16 * i + y);
        n_cmp++; if (acc[i].data[y] !== e) begin n_bad++; $display("FAIL basic_data r=%0d l=%0d got=%0d exp=%0d", i, y, acc[i].data[y], e); end
      end
      n_cmp++; if (acc[i].sat !== 1'b0) begin n_bad++; $display("FAIL basic_sat r=%0d got=%b exp=0", i, acc[i].sat); end
      n_cmp++; if (acc[i].last !== (i == X - 1)) begin n_bad++; $display("FAIL basic_last r=%0d got=%b", i, acc[i].last); end
    end
    n_cmp++; if (done_k !== X + 2) begin n_bad++; $display("FAIL basic_done got=%0d exp=%0d", done_k, X + 2); end
    n_cmp++; if (busy_done !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done got=%b exp=0", busy_done); end
    n_cmp++; if (err_n !== 0) begin n_bad++; $display("FAIL basic_err got=%0d exp=0", err_n); end
  endtask

  task automatic test_arith();
    int cv0[5] = '{300, 32767, 384, -5, -5};
    int cv1[5] = '{-300, 0, -6, 5, 7};
    int cs[5]  = '{0, 8, 2, 1, 0};
    bit cr[5]  = '{0, 0, 0, 0, 1};
    int e0[5]  = '{127, 127, 96, -2, 0};
    int e1[5]  = '{-128, 0, -1, 3, 7};
    bit esat[5] = '{1, 1, 0, 0, 0};
    mat_t m;
    row_t ed;
    logic es;
    logic [O-1:0] g0, g1;
    for (int c = 0; c < 5; c++) begin
      m = rand_mat();
      m[0] = '0;
      m[0][0] = A'(cv0[c]);
      m[0][1] = A'(cv1[c]);
      start_capture(m, cr[c], cs[c]);
      collect(64'h0, -1, 1'b0);
      n_cmp++; if (acc.size() !== X) begin n_bad++; $display("FAIL arith_count c=%0d got=%0d exp=%0d", c, acc.size(), X); end
      if (acc.size() > 0) begin
        g0 = O'(e0[c]); g1 = O'(e1[c]);
        n_cmp++; if (acc[0].data[0] !== g0) begin n_bad++; $display("FAIL arith_l0 c=%0d got=%0d exp=%0d", c, $signed(acc[0].data[0]), e0[c]); end
        n_cmp++; if (acc[0].data[1] !== g1) begin n_bad++; $display("FAIL arith_l1 c=%0d got=%0d exp=%0d", c, $signed(acc[0].data[1]), e1[c]); end
        n_cmp++; if (acc[0].sat !== esat[c]) begin n_bad++; $display("FAIL arith_sat c=%0d got=%b exp=%b", c, acc[0].sat, esat[c]); end
      end
      foreach (acc[i]) begin
        model_row(m, cr[c], cs[c], i, ed, es);
        n_cmp++; if (acc[i].data !== ed) begin n_bad++; $display("FAIL arith_row c=%0d r=%0d got=%h exp=%h", c, i, acc[i].data, ed); end
        n_cmp++; if (acc[i].sat !== es) begin n_bad++; $display("FAIL arith_rowsat c=%0d r=%0d got=%b exp=%b", c, i, acc[i].sat, es); end
      end
    end
  endtask

  task automatic test_backpressure();
    mat_t m;
    row_t ed;
    logic es;
    int n1;
    int ek[4] = '{2, 6, 7, 8};
    m = rand_mat();
    start_capture(m, 1'b0, 2);
    collect(64'h38, -1, 1'b0);
    n_cmp++; if (acc.size() !== X) begin n_bad++; $display("FAIL bp_count got=%0d exp=%0d", acc.size(), X); end
    foreach (acc[i]) begin
      n_cmp++; if (acc[i].row !== i) begin n_bad++; $display("FAIL bp_row got=%0d exp=%0d", acc[i].row, i); end
      n_cmp++; if (acc[i].k !== ek[i]) begin n_bad++; $display("FAIL bp_cycle r=%0d got=%0d exp=%0d", i, acc[i].k, ek[i]); end
    end
    n1 = 0;
    model_row(m, 1'b0, 2, 1, ed, es);
    foreach (shown[i]) begin
      if (shown[i].row == 1) begin
        n1++;
        n_cmp++; if ({shown[i].data, shown[i].sat, shown[i].last} !== {ed, es, 1'b0})
          begin n_bad++; $display("FAIL bp_hold k=%0d got=%h exp=%h", shown[i].k, shown[i].data, ed); end
      end
    end
    n_cmp++; if (n1 !== 4) begin n_bad++; $display("FAIL bp_row1_cycles got=%0d exp=4", n1); end
    n_cmp++; if (done_k !== X + 2 + 3) begin n_bad++; $display("FAIL bp_done got=%0d exp=%0d", done_k, X + 5); end
  endtask

  task automatic test_collision();
    mat_t m;
    row_t ed;
    logic es;
    int pk[2] = '{1, 3};
    for (int p = 0; p < 2; p++) begin
      m = rand_mat();
      start_capture(m, 1'b1, 1);
      collect(64'h0, pk[p], 1'b0);
      n_cmp++; if (err_n !== 1) begin n_bad++; $display("FAIL coll_err_n p=%0d got=%0d exp=1", pk[p], err_n); end
      n_cmp++; if (err_k !== pk[p] + 1) begin n_bad++; $display("FAIL coll_err_k got=%0d exp=%0d", err_k, pk[p] + 1); end
      n_cmp++; if (acc.size() !== X) begin n_bad++; $display("FAIL coll_count got=%0d exp=%0d", acc.size(), X); end
      foreach (acc[i]) begin
        model_row(m, 1'b1, 1, i, ed, es);
        n_cmp++; if ({acc[i].data, acc[i].sat, acc[i].row, acc[i].k} !== {ed, es, i, i + 2})
          begin n_bad++; $display("FAIL coll_beat r=%0d got=%h/%0d/%0d exp=%h/%0d/%0d", i, acc[i].data, acc[i].row, acc[i].k, ed, i, i + 2); end
      end
      n_cmp++; if (done_k !== X + 2) begin n_bad++; $display("FAIL coll_done got=%0d exp=%0d", done_k, X + 2); end
    end
  endtask

  task automatic test_done_capture();
    mat_t m1, m2;
    row_t ed;
    logic es;
    m1 = rand_mat();
    m2 = rand_mat();
    start_capture(m1, 1'b0, 0);
    collect(64'h0, -1, 1'b0);
    n_cmp++; if (done_k !== X + 2) begin n_bad++; $display("FAIL dcap_done got=%0d exp=%0d", done_k, X + 2); end
    start_capture(m2, 1'b1, 4);
    collect(64'h0, -1, 1'b0);
    n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL dcap_busy got=%b exp=1", busy1); end
    n_cmp++; if (err_n !== 0) begin n_bad++; $display("FAIL dcap_err got=%0d exp=0", err_n); end
    n_cmp++; if (acc.size() !== X) begin n_bad++; $display("FAIL dcap_count got=%0d exp=%0d", acc.size(), X); end
    if (acc.size() > 0) begin
      n_cmp++; if (acc[0].k !== 2) begin n_bad++; $display("FAIL dcap_row0_cycle got=%0d exp=2", acc[0].k); end
    end
    foreach (acc[i]) begin
      model_row(m2, 1'b1, 4, i, ed, es);
      n_cmp++; if ({acc[i].data, acc[i].sat} !== {ed, es}) begin n_bad++; $display("FAIL dcap_data r=%0d got=%h exp=%h", i, acc[i].data, ed); end
    end
  endtask

  task automatic test_settings();
    mat_t m;
    row_t ed;
    logic es;
    bit rl[2] = '{1, 0};
    int sh[2] = '{3, 0};
    for (int p = 0; p < 2; p++) begin
      m = rand_mat();
      start_capture(m, rl[p], sh[p]);
      collect(64'h0, -1, 1'b1);
      n_cmp++; if (acc.size() !== X) begin n_bad++; $display("FAIL set_count got=%0d exp=%0d", acc.size(), X); end
      foreach (acc[i]) begin
        model_row(m, rl[p], sh[p], i, ed, es);
        n_cmp++; if ({acc[i].data, acc[i].sat} !== {ed, es}) begin n_bad++; $display("FAIL set_data p=%0d r=%0d got=%h exp=%h", p, i, acc[i].data, ed); end
      end
    end
  endtask

  task automatic test_random();
    mat_t m;
    row_t ed;
    logic es;
    logic [63:0] stall;
    bit rl;
    int sh, r, dk;
    for (int it = 0; it < 8; it++) begin
      m = rand_mat();
      rl = 1'($urandom);
      sh = $urandom_range(0, A - 1);
      stall = {32'h0, $urandom & 32'h000F_FFFC};
      r = 0; dk = -1;
      for (int k = 2; k <= 60 && dk < 0; k++) begin
        if (!stall[k]) begin
          r++;
          if (r == X) dk = k + 1;
        end
      end
      start_capture(m, rl, sh);
      collect(stall, -1, 1'b0);
      n_cmp++; if (done_k !== dk) begin n_bad++; $display("FAIL rnd_done it=%0d got=%0d exp=%0d", it, done_k, dk); end
      n_cmp++; if (shown.size() !== dk - 2) begin n_bad++; $display("FAIL rnd_valid_cycles it=%0d got=%0d exp=%0d", it, shown.size(), dk - 2); end
      n_cmp++; if (acc.size() !== X) begin n_bad++; $display("FAIL rnd_count it=%0d got=%0d exp=%0d", it, acc.size(), X); end
      foreach (acc[i]) begin
        model_row(m, rl, sh, i, ed, es);
        n_cmp++; if ({acc[i].data, acc[i].sat, acc[i].row, acc[i].last} !== {ed, es, i, i == X - 1})
          begin n_bad++; $display("FAIL rnd_beat it=%0d r=%0d got=%h/%b/%0d exp=%h/%b/%0d", it, i, acc[i].data, acc[i].sat, acc[i].row, ed, es, i); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_backpressure();
    test_collision();
    test_done_capture();
    test_settings();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/of_drain_unit.md
# of_drain_unit

Output-feature drain engine for the PE array. It snapshots the full X_DIM×Y_DIM partial-sum array in one cycle, then streams it out one row per beat over a valid/ready interface. Each element goes through optional ReLU, rounding right-shift requantisation and signed saturation on the way out. It sits between the PE array outputs and the SRAM/output FIFO path, so the array can start the next tile while the previous one drains.

## Interface
Parameters:
- X_DIM, 16: number of rows; one row is streamed per beat.
- Y_DIM, 16: number of lanes per beat (columns).
- ACC_WIDTH, 16: signed accumulator width of each PE output.
- OUT_WIDTH, 8: signed output element width; must satisfy 2 ≤ OUT_WIDTH ≤ ACC_WIDTH.
- SH_W, $clog2(ACC_WIDTH): width of shift_amt.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pe_of_in  in  [ACC_WIDTH-1:0] [X_DIM-1:0][Y_DIM-1:0]  PE array partial sums, signed.
- capture_req  in  1  request to snapshot pe_of_in.
- relu_en  in  1  ReLU enable; sampled with capture.
- shift_amt  in  SH_W  requantisation right-shift; sampled with capture.
- busy  out  1  high from an accepted capture until the last beat is accepted.
- capture_err  out  1  one-cycle pulse when capture_req is ignored.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  [OUT_WIDTH-1:0] [Y_DIM-1:0]  requantised row, signed.
- out_row  out  $clog2(X_DIM)  row index of the current beat.
- out_last  out  1  high on the beat where out_row == X_DIM-1.
- sat_flag  out  1  high if any lane of the current beat saturated.
- done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- FSM states: IDLE, PREP, DRAIN.
- IDLE:
  - capture_req=1 loads the shadow array from pe_of_in, latches relu_en and shift_amt, clears the row pointer, asserts busy and moves to PREP.
- PREP:
  - Computes row 0 into the output register.
  - Sets out_valid=1 and moves to DRAIN.
- DRAIN:
  - On out_valid && out_ready, the output register loads the next row (pointer+1) in the same edge.
  - When the accepted beat is the last row: out_valid=0, busy=0, done=1 for the next cycle, state returns to IDLE.
- Per-element arithmetic (v = signed ACC_WIDTH element, s = latched shift):
  - If relu_en and v<0, then v=0.
  - If s>0, compute (v + 2^(s-1)) >>> s in ACC_WIDTH+1 bits (round half up); if s=0, use v unchanged.
  - Saturate the result to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - sat_flag = OR of the per-lane clamp events for that row.
- capture_req while busy (PREP or DRAIN):
  - The request is ignored; capture_err pulses the next cycle.
  - Shadow, settings and stream are unaffected.
- capture_req in the cycle done is high: the state is IDLE, so the request is accepted normally.
- pe_of_in may change freely after the capture edge; only the shadow copy is used.

## Timing
- Reset values: busy=0, capture_err=0, out_valid=0, out_data=0, out_row=0, out_last=0, sat_flag=0, done=0, state=IDLE. The shadow array clears to 0.
- Reset asserted mid-drain aborts immediately. No done pulse is produced, and the stream restarts only on a new capture.
- capture_req sampled at edge N:
  - busy=1 from N+1.
  - out_valid=1 with row 0 from N+2.
- With out_ready held high: one row per cycle, so rows 0..X_DIM-1 appear on cycles N+2 .. N+X_DIM+1.
- done pulses at N+X_DIM+2.
- Minimum capture-to-capture interval: X_DIM+2 cycles.
- Backpressure: while out_valid && !out_ready, out_data, out_row, out_last and sat_flag stay stable.
- out_valid never drops before its beat is accepted.

## Test plan
- Reset: drive rst=0 mid-operation → every output is 0 within the same cycle (asynchronous reset); after release, out_valid stays 0 until a capture.
- Basic drain (X=Y=4, ACC=16, OUT=8): acc[x][y]=16x+y, s=0, ReLU off, ready=1, capture at cycle 0 →
  - rows 0..3 on cycles 2..5, with row r lanes = 16r..16r+3;
  - out_last on cycle 5, done on cycle 6, sat_flag=0 throughout.
- Arithmetic:
  - s=0: 300→127 and −300→−128, both with sat_flag=1.
  - s=8: 0x7FFF→127 (sat); 384 with s=2 → 96.
  - s=1: −5 → −2.
  - ReLU on: −5 → 0.
- Backpressure: hold ready=0 for 3 cycles while row 1 is presented → row 1 held and stable; rows 2..3 follow back-to-back once ready rises; done is delayed by exactly 3 cycles.
- Capture collisions:
  - capture_req during DRAIN → capture_err pulse, stream bit-identical to an undisturbed run.
  - capture_req in the done cycle → accepted, new row 0 appears 2 cycles later.
- Settings latch: change shift_amt and relu_en during a drain → the current stream uses the captured values; the next capture uses the new ones.
